sobel_filter: RTL
=================

# sobel_filter

Pipelined Sobel gradient stage of the Canny edge chain. It sits downstream of `gaussian_filter`. A second `pixel_loader` instance converts the Gaussian pixel stream into 3x3 windows, and this block consumes those windows. For each window it outputs a saturated 8-bit gradient magnitude and a 2-bit quantized gradient direction, which feed non-maximum suppression. It also counts the outputs of each frame and pulses a frame-done flag.

## Interface
- `FRAME_PIXELS`, default 258064 (508x508 valid windows from a 512x512 source after two 3x3 stages), number of outputs per frame.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstN`  in  1  synchronous reset, active-high. The codebase name is retained; asserted = 1.
- `sobel_data_in`  in  72  3x3 window. Pixel p[r][c] occupies bits [8*(3r+c)+7 : 8*(3r+c)]. r=0 is the top row; c=0 is the left column.
- `sobel_data_in_valid`  in  1  window qualifier, one window per cycle when high.
- `sobel_mag_out`  out  8  min(|Gx|+|Gy|, 255).
- `sobel_dir_out`  out  2  0 = 0°, 1 = 45°, 2 = 90°, 3 = 135°.
- `sobel_out_valid`  out  1  qualifies mag and dir.
- `sobel_frame_done`  out  1  one-cycle pulse, coincident with the FRAME_PIXELS-th valid output of a frame.

## Operation
- Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20). Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02). Both are 11-bit signed, range ±1020, and never overflow.
- ax = |Gx| and ay = |Gy|, each 10-bit unsigned. sum = ax + ay, 11-bit. Magnitude saturates to 255 when sum > 255.
- Direction uses Q8 constants T1 = 106 (tan 22.5°) and T2 = 618 (tan 67.5°). Products are 20-bit unsigned, with no truncation.
  - If ay·256 ≤ ax·T1, dir = 0.
  - Else if ay·256 ≥ ax·T2, dir = 2.
  - Else if sign(Gx) = sign(Gy), dir = 1; otherwise dir = 3.
- A zero gradient (ax = ay = 0) gives dir = 0 and mag = 0.
- There is no backpressure. The block accepts a window every cycle that `sobel_data_in_valid` is high, and input gaps propagate as output gaps.
- Frame counter:
  - A counter of log2(FRAME_PIXELS) bits increments on each valid output.
  - When the count reaches FRAME_PIXELS−1 and an output is valid, `sobel_frame_done` pulses and the counter wraps to 0 on the same edge.
  - There is no other frame marker.

## Timing
- Latency is exactly 3 cycles from input valid to output valid. Throughput is 1 window per cycle.
- S1 registers Gx and Gy.
- S2 registers ax, ay, the sign-equality bit, the 11-bit sum, and both comparison results.
- S3 registers the saturated mag, dir, valid and frame_done.
- A valid bit travels with each stage. Data registers may hold stale values when their valid bit is low; the bench checks data only when `sobel_out_valid` = 1.
- Reset values: `sobel_mag_out` = 0, `sobel_dir_out` = 0, `sobel_out_valid` = 0, `sobel_frame_done` = 0, all stage valid bits = 0, frame counter = 0.
- Reset mid-operation: in-flight windows are discarded and the counter clears on that edge. No output valid appears until 3 cycles after the first valid input following deassertion.
- Input valid held high during reset is ignored.
- Back-to-back frames: the frame-done pulse and the first output of the next frame may occur on consecutive cycles, with no dead cycle.

## Structure
- `sobel_pkg` contains:
  - `sobel_dir_t`, a 2-bit enum: DIR_0, DIR_45, DIR_90, DIR_135.
  - Constants TAN22_Q8 = 106, TAN67_Q8 = 618, MAG_MAX = 255.
  - The window bit-index function `win_px(r, c)`.
- Sub-module `sobel_dir_quantizer` holds the S2/S3 direction logic. Its inputs are ax, ay and the sign-equality bit; its output is a registered `sobel_dir_t`.
- The top level holds S1, the magnitude path, the valid chain and the frame counter.

## Test plan
- Right column = 10, all else 0 -> Gx = 40, Gy = 0; mag = 40, dir = 0, exactly 3 cycles after input valid.
- Bottom row = 5, all else 0 -> Gy = 20; mag = 20, dir = 2.
- p22 = 20 only -> mag = 40, dir = 1. p20 = 20 only -> Gx = −20, Gy = 20; mag = 40, dir = 3.
- Saturation and flat input:
  - Left column 0, right column 255 -> Gx = 1020; mag = 255, dir = 0.
  - Uniform 128 -> mag = 0, dir = 0.
- Streaming with FRAME_PIXELS = 4:
  - Stimulus: 10 valid windows with a 2-cycle input gap after window 3.
  - Required: `sobel_frame_done` pulses on outputs 4 and 8 only, and the output valid pattern mirrors the input pattern delayed by 3 cycles.
- Reset asserted for 1 cycle while 2 windows are in flight:
  - Required: no valid output from those windows, and the counter restarts, so the next frame_done comes after 4 further outputs.

Source files
------------

// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg
//   Shared types and constants for the Sobel gradient stage.
//   - sobel_dir_t : quantized gradient direction (0, 45, 90, 135 degrees)
//   - TAN22_Q8 / TAN67_Q8 : tan(22.5) and tan(67.5) in Q8 fixed point
//   - MAG_MAX : saturation ceiling of the 8-bit magnitude
//   - win_px(r, c) : LSB index of pixel p[r][c] inside the 72-bit window
// ---------------------------------------------------------------------------
package sobel_pkg;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } sobel_dir_t;

  localparam int TAN22_Q8 = 106;
  localparam int TAN67_Q8 = 618;
  localparam int MAG_MAX  = 255;

  localparam int PIX_W = 8;
  localparam int WIN_W = 9 * PIX_W;

  // Row-major packing: p[0][0] in the low byte, p[2][2] in the high byte.
  function automatic int win_px(input int r, input int c);
    return PIX_W * (3 * r + c);
  endfunction

endpackage

// File: rtl/sobel_dir_quantizer.sv
// ---------------------------------------------------------------------------
// sobel_dir_quantizer
//   Two-register direction quantizer (pipeline stages S2 and S3).
//   S2 registers the two threshold comparisons and the sign-equality bit;
//   S3 resolves them into a registered direction code.
//
//   Ports:
//     clk      in   clock, rising edge
//     rstN     in   synchronous reset, active-high
//     ax       in   |Gx|, 10-bit unsigned (combinational, from S1 registers)
//     ay       in   |Gy|, 10-bit unsigned (combinational, from S1 registers)
//     sign_eq  in   1 when Gx and Gy have the same sign
//     dir      out  registered sobel_dir_t (S3)
// ---------------------------------------------------------------------------
module sobel_dir_quantizer
  import sobel_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic       sign_eq,
  output sobel_dir_t dir
);

  // Compare ay/ax against tan thresholds without division:
  // ay/ax <= tan(22.5)  <=>  ay*256 <= ax*T1  (products fit 20 bits).
  logic [19:0] ay_q8;
  logic [19:0] ax_t1;
  logic [19:0] ax_t2;

  assign ay_q8 = {2'b00, ay, 8'h00};
  assign ax_t1 = 20'(ax) * 20'(TAN22_Q8);
  assign ax_t2 = 20'(ax) * 20'(TAN67_Q8);

  logic le_t1_s2;
  logic ge_t2_s2;
  logic sign_eq_s2;

  // S2: comparison results
  always_ff @(posedge clk) begin
    if (rstN) begin
      le_t1_s2   <= 1'b0;
      ge_t2_s2   <= 1'b0;
      sign_eq_s2 <= 1'b0;
    end else begin
      le_t1_s2   <= (ay_q8 <= ax_t1);
      ge_t2_s2   <= (ay_q8 >= ax_t2);
      sign_eq_s2 <= sign_eq;
    end
  end

  // S3: priority resolve. A zero gradient satisfies le_t1 (0 <= 0) and
  // therefore lands on DIR_0.
  always_ff @(posedge clk) begin
    if (rstN) begin
      dir <= DIR_0;
    end else if (le_t1_s2) begin
      dir <= DIR_0;
    end else if (ge_t2_s2) begin
      dir <= DIR_90;
    end else if (sign_eq_s2) begin
      dir <= DIR_45;
    end else begin
      dir <= DIR_135;
    end
  end

endmodule

// File: rtl/sobel_filter.sv
// ---------------------------------------------------------------------------
// sobel_filter
//   Three-stage pipelined Sobel gradient: per 3x3 window it produces a
//   saturated 8-bit magnitude |Gx|+|Gy| and a 2-bit quantized direction,
//   and pulses a frame-done flag on the FRAME_PIXELS-th output of a frame.
//
//   Parameters:
//     FRAME_PIXELS  number of outputs per frame
//
//   Ports:
//     clk                  in   clock, rising edge
//     rstN                 in   synchronous reset, active-high
//     sobel_data_in        in   72-bit window, p[r][c] at bits 8*(3r+c) +: 8
//     sobel_data_in_valid  in   window qualifier
//     sobel_mag_out        out  min(|Gx|+|Gy|, 255)
//     sobel_dir_out        out  0=0deg, 1=45deg, 2=90deg, 3=135deg
//     sobel_out_valid      out  qualifies mag/dir
//     sobel_frame_done     out  one-cycle pulse with the last output of a frame
//
//   Handshake: valid-only, no ready. A window is taken on every rising edge
//   where sobel_data_in_valid is high; sobel_out_valid rises exactly three
//   edges later and input gaps reappear as output gaps. Data outputs are
//   meaningful only while sobel_out_valid is high.
// ---------------------------------------------------------------------------
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int FRAME_PIXELS = 258064
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIN_W-1:0] sobel_data_in,
  input  logic             sobel_data_in_valid,
  output logic [7:0]       sobel_mag_out,
  output logic [1:0]       sobel_dir_out,
  output logic             sobel_out_valid,
  output logic             sobel_frame_done
);

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);

  // Zero-extended pixel as an 11-bit signed operand.
  function automatic logic signed [10:0] px(input logic [WIN_W-1:0] w,
                                            input int r, input int c);
    return $signed({3'b000, w[win_px(r, c) +: PIX_W]});
  endfunction

  // ---------------- S1: gradients ----------------
  logic signed [10:0] gx_c;
  logic signed [10:0] gy_c;

  always_comb begin
    gx_c = (px(sobel_data_in, 0, 2) + (px(sobel_data_in, 1, 2) <<< 1)
            + px(sobel_data_in, 2, 2))
         - (px(sobel_data_in, 0, 0) + (px(sobel_data_in, 1, 0) <<< 1)
            + px(sobel_data_in, 2, 0));
    gy_c = (px(sobel_data_in, 2, 0) + (px(sobel_data_in, 2, 1) <<< 1)
            + px(sobel_data_in, 2, 2))
         - (px(sobel_data_in, 0, 0) + (px(sobel_data_in, 0, 1) <<< 1)
            + px(sobel_data_in, 0, 2));
  end

  logic signed [10:0] gx_s1;
  logic signed [10:0] gy_s1;
  logic               v_s1;

  always_ff @(posedge clk) begin
    if (rstN) begin
      gx_s1 <= '0;
      gy_s1 <= '0;
      v_s1  <= 1'b0;
    end else begin
      gx_s1 <= gx_c;
      gy_s1 <= gy_c;
      v_s1  <= sobel_data_in_valid;
    end
  end

  // ---------------- S2: abs, sum ----------------
  // |G| <= 1020, so the absolute value always fits the low 10 bits.
  logic [9:0]  ax_c;
  logic [9:0]  ay_c;
  logic        sign_eq_c;
  logic [10:0] sum_c;

  assign ax_c      = 10'(gx_s1[10] ? -gx_s1 : gx_s1);
  assign ay_c      = 10'(gy_s1[10] ? -gy_s1 : gy_s1);
  assign sign_eq_c = (gx_s1[10] == gy_s1[10]);
  assign sum_c     = {1'b0, ax_c} + {1'b0, ay_c};

  logic [10:0] sum_s2;
  logic        v_s2;

  always_ff @(posedge clk) begin
    if (rstN) begin
      sum_s2 <= '0;
      v_s2   <= 1'b0;
    end else begin
      sum_s2 <= sum_c;
      v_s2   <= v_s1;
    end
  end

  // Direction path owns its own S2/S3 registers.
  sobel_dir_t dir_s3;

  sobel_dir_quantizer u_dir (
    .clk     (clk),
    .rstN    (rstN),
    .ax      (ax_c),
    .ay      (ay_c),
    .sign_eq (sign_eq_c),
    .dir     (dir_s3)
  );

  // ---------------- S3: saturate, valid, frame count ----------------
  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rstN) begin
      sobel_mag_out <= '0;
      sobel_out_valid <= 1'b0;
    end else begin
      sobel_mag_out   <= (sum_s2 > 11'(MAG_MAX)) ? 8'(MAG_MAX) : sum_s2[7:0];
      sobel_out_valid <= v_s2;
    end
  end

  // The counter advances with the output it accounts for, so the pulse and
  // the wrap land on the same edge and the next frame can start immediately.
  always_ff @(posedge clk) begin
    if (rstN) begin
      frame_cnt        <= '0;
      sobel_frame_done <= 1'b0;
    end else if (v_s2) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt        <= '0;
        sobel_frame_done <= 1'b1;
      end else begin
        frame_cnt        <= frame_cnt + CNT_W'(1);
        sobel_frame_done <= 1'b0;
      end
    end else begin
      sobel_frame_done <= 1'b0;
    end
  end

  assign sobel_dir_out = dir_s3;

endmodule
